// File: rtl/md_pkg.sv
// Shared encodings for the E-stage multiply/divide unit: op codes, scheduler
// states and default busy-window lengths.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Ops that occupy the unit for a multi-cycle busy window.
  function automatic logic is_busy_op(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_scheduler_if.sv
// E-stage side of the multiply/divide unit: operands and op from E, the D-stage
// MD hint, and the HI/LO read, stall and busy results.
interface md_scheduler_if;
  import md_pkg::*;

  logic        E_valid;
  md_op_e      E_md_op;
  logic [31:0] E_data1;
  logic [31:0] E_data2;
  logic        D_is_md;
  logic [31:0] E_HL_data;
  logic        E_MD_stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output E_valid, E_md_op, E_data1, E_data2, D_is_md,
    input  E_HL_data, E_MD_stall, busy, hi, lo
  );

  modport slave (
    input  E_valid, E_md_op, E_data1, E_data2, D_is_md,
    output E_HL_data, E_MD_stall, busy, hi, lo
  );

endinterface

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath. Signed ops run through a single
// unsigned multiplier/divider on sign-extended operands or magnitudes.
module md_compute
  import md_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        wr_en
);

  logic        signed_op;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] den;
  logic [31:0] quot_m;
  logic [31:0] rem_m;
  logic [31:0] quot;
  logic [31:0] rem;

  // 0x80000000 / -1 falls out naturally: magnitude quotient 0x80000000 negates to itself.
  always_comb begin
    signed_op = (op == MD_MULT) || (op == MD_DIV);
    mul_a     = signed_op ? {{32{a[31]}}, a} : {32'h0, a};
    mul_b     = signed_op ? {{32{b[31]}}, b} : {32'h0, b};
    prod      = mul_a * mul_b;
    mag_a     = (signed_op && a[31]) ? -a : a;
    mag_b     = (signed_op && b[31]) ? -b : b;
    den       = (b == 32'h0) ? 32'd1 : mag_b;
    quot_m    = mag_a / den;
    rem_m     = mag_a % den;
    quot      = (signed_op && (a[31] ^ b[31])) ? -quot_m : quot_m;
    rem       = (signed_op && a[31]) ? -rem_m : rem_m;
    hi_res    = 32'h0;
    lo_res    = 32'h0;
    wr_en     = 1'b0;
    case (op)
      MD_MULT, MD_MULTU: begin
        hi_res = prod[63:32];
        lo_res = prod[31:0];
        wr_en  = 1'b1;
      end
      MD_DIV, MD_DIVU: begin
        hi_res = rem;
        lo_res = quot;
        wr_en  = (b != 32'h0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_scheduler.sv
// Busy-window sequencer for the multiply/divide unit. Owns HI/LO, latches the
// result at start and commits it on the last busy cycle.
module md_scheduler
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          rst,
  md_scheduler_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       hi_reg;
  logic [31:0]       lo_reg;
  logic [31:0]       hi_pend;
  logic [31:0]       lo_pend;
  logic              pend_wr;
  logic              start;
  logic [31:0]       c_hi;
  logic [31:0]       c_lo;
  logic              c_wr;

  md_compute u_compute (
    .op     (bus.E_md_op),
    .a      (bus.E_data1),
    .b      (bus.E_data2),
    .hi_res (c_hi),
    .lo_res (c_lo),
    .wr_en  (c_wr)
  );

  assign start = bus.E_valid && is_busy_op(bus.E_md_op) && (state == IDLE);

  // A divide by zero still runs its window; pend_wr suppresses the commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_reg  <= '0;
      lo_reg  <= '0;
      hi_pend <= '0;
      lo_pend <= '0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            cnt     <= is_div_op(bus.E_md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            hi_pend <= c_hi;
            lo_pend <= c_lo;
            pend_wr <= c_wr;
          end else if (bus.E_valid && (bus.E_md_op == MD_MTHI)) begin
            hi_reg <= bus.E_data1;
          end else if (bus.E_valid && (bus.E_md_op == MD_MTLO)) begin
            lo_reg <= bus.E_data1;
          end
        end
        RUN: begin
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            cnt   <= '0;
            if (pend_wr) begin
              hi_reg <= hi_pend;
              lo_reg <= lo_pend;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (bus.E_md_op)
      MD_MFHI: bus.E_HL_data = hi_reg;
      MD_MFLO: bus.E_HL_data = lo_reg;
      default: bus.E_HL_data = 32'h0;
    endcase
  end

  assign bus.busy       = (state == RUN);
  assign bus.E_MD_stall = bus.D_is_md && (bus.busy || start);
  assign bus.hi         = hi_reg;
  assign bus.lo         = lo_reg;

  // The stall keeps MD ops out of E while busy; any that slip through are dropped.
  no_md_op_while_busy: assert property (@(posedge clk) disable iff (!rst)
    !((state == RUN) && bus.E_valid && (bus.E_md_op != MD_NONE)));

endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler: expected HI/LO pairs are queued at each start
// and popped when the busy window closes.
module tb_md_scheduler;
  import md_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t exp_q[$];
  logic [31:0] ra;
  logic [31:0] rb;
  logic [63:0] rprod;

  md_scheduler_if bus_if ();

  md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input logic v, input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    bus_if.E_valid = v;
    bus_if.E_md_op = op;
    bus_if.E_data1 = a;
    bus_if.E_data2 = b;
  endtask

  task automatic check_commit(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: scoreboard empty, got hi=%h lo=%h", tag, bus_if.hi, bus_if.lo);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_hi"}, bus_if.hi, e.hi);
      chk({tag, "_lo"}, bus_if.lo, e.lo);
    end
  endtask

  // Presents a start in the current cycle; optionally checks the previous commit at the same point.
  task automatic start_op(input string tag, input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic d_md, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic prev_commit);
    exp_t e;
    set_e(1'b1, op, a, b);
    bus_if.D_is_md = d_md;
    @(negedge clk);
    if (prev_commit) check_commit({tag, "_prev"});
    chk({tag, "_idle_at_start"}, 32'(bus_if.busy), 32'd0);
    chk({tag, "_start_stall"}, 32'(bus_if.E_MD_stall), 32'(d_md));
    e.hi = exp_hi;
    e.lo = exp_lo;
    exp_q.push_back(e);
    next_cycle();
    set_e(1'b0, MD_NONE, 32'h0, 32'h0);
  endtask

  task automatic wait_busy(input string tag, input int n, input logic d_md);
    bus_if.D_is_md = d_md;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      chk($sformatf("%s_busy%0d", tag, i), 32'(bus_if.busy), 32'd1);
      chk($sformatf("%s_stall%0d", tag, i), 32'(bus_if.E_MD_stall), 32'(d_md));
      next_cycle();
    end
  endtask

  task automatic finish_op(input string tag);
    @(negedge clk);
    chk({tag, "_busy_end"}, 32'(bus_if.busy), 32'd0);
    chk({tag, "_stall_end"}, 32'(bus_if.E_MD_stall), 32'd0);
    check_commit(tag);
    next_cycle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    set_e(1'b0, MD_MFHI, 32'h0, 32'h0);
    bus_if.D_is_md = 1'b1;

    // Reset state
    #3;
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_stall", 32'(bus_if.E_MD_stall), 32'd0);
    chk("rst_hl", bus_if.E_HL_data, 32'h0);
    chk("rst_hi", bus_if.hi, 32'h0);
    chk("rst_lo", bus_if.lo, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    set_e(1'b0, MD_NONE, 32'h0, 32'h0);
    bus_if.D_is_md = 1'b0;

    // multu with mfhi stalled in D, then mfhi reads committed HI
    start_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b1, 32'h1, 32'hFFFF_FFFE, 1'b0);
    wait_busy("multu", 5, 1'b1);
    set_e(1'b1, MD_MFHI, 32'h0, 32'h0);
    bus_if.D_is_md = 1'b0;
    finish_op("multu");
    @(negedge clk);
    set_e(1'b1, MD_MFHI, 32'h0, 32'h0);
    #1;
    chk("mfhi_after_multu", bus_if.E_HL_data, 32'h1);
    next_cycle();
    set_e(1'b0, MD_NONE, 32'h0, 32'h0);

    // mult -3*7 with a non-MD instruction in D
    start_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    wait_busy("mult", 5, 1'b0);
    finish_op("mult");

    // div -7/2, then divu by zero leaves HI/LO untouched
    start_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    wait_busy("div", 10, 1'b0);
    finish_op("div");
    start_op("divu0", MD_DIVU, 32'd7, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    wait_busy("divu0", 10, 1'b0);
    finish_op("divu0");

    // Signed overflow case
    start_op("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000, 1'b0);
    wait_busy("divovf", 10, 1'b0);
    finish_op("divovf");

    // mtlo then mflo on the following cycle, no stall
    set_e(1'b1, MD_MTLO, 32'h1234_5678, 32'h0);
    bus_if.D_is_md = 1'b1;
    @(negedge clk);
    chk("mtlo_stall", 32'(bus_if.E_MD_stall), 32'd0);
    next_cycle();
    set_e(1'b1, MD_MFLO, 32'h0, 32'h0);
    bus_if.D_is_md = 1'b0;
    @(negedge clk);
    chk("mflo_after_mtlo", bus_if.E_HL_data, 32'h1234_5678);
    chk("mflo_stall", 32'(bus_if.E_MD_stall), 32'd0);
    next_cycle();
    set_e(1'b1, MD_MTHI, 32'hCAFE_0001, 32'h0);
    next_cycle();
    set_e(1'b1, MD_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    chk("mfhi_after_mthi", bus_if.E_HL_data, 32'hCAFE_0001);
    next_cycle();
    set_e(1'b0, MD_NONE, 32'h0, 32'h0);

    // Reset during busy cycle 3 of a div discards the pending result
    start_op("divrst", MD_DIVU, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0);
    wait_busy("divrst", 2, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    set_e(1'b0, MD_MFLO, 32'h0, 32'h0);
    #1;
    void'(exp_q.pop_back());
    chk("midrst_busy", 32'(bus_if.busy), 32'd0);
    chk("midrst_hi", bus_if.hi, 32'h0);
    chk("midrst_lo", bus_if.lo, 32'h0);
    chk("midrst_hl", bus_if.E_HL_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    set_e(1'b1, MD_MFLO, 32'h0, 32'h0);
    @(negedge clk);
    chk("mflo_after_rst", bus_if.E_HL_data, 32'h0);
    next_cycle();
    start_op("mult_post_rst", MD_MULT, 32'd6, 32'd7, 1'b0, 32'h0, 32'd42, 1'b0);
    wait_busy("mult_post_rst", 5, 1'b0);
    finish_op("mult_post_rst");

    // Back-to-back: div stalled in D enters E exactly one cycle after the window
    start_op("b2b_mult", MD_MULT, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h1, 32'h0, 1'b0);
    wait_busy("b2b_mult", 5, 1'b1);
    start_op("b2b_div", MD_DIV, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b1);
    wait_busy("b2b_div", 10, 1'b0);
    finish_op("b2b_div");

    // Random multu against a 64-bit product
    ra = $urandom;
    rb = $urandom;
    rprod = {32'h0, ra} * {32'h0, rb};
    start_op("rand_multu", MD_MULTU, ra, rb, 1'b0, rprod[63:32], rprod[31:0], 1'b0);
    wait_busy("rand_multu", 5, 1'b0);
    finish_op("rand_multu");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_scheduler.md
# md_scheduler

Sequencer for the E-stage multiply/divide resource of the five-stage pipeline. It accepts HI/LO-class operations from the E stage and runs multiply/divide for a fixed multi-cycle busy window. It owns the HI and LO registers and raises the E_MD_stall request consumed by AT_controller, so that D-stage HI/LO-class instructions wait while the unit is occupied.

## Interface

Parameters:
- MULT_CYCLES, default 5: busy cycles for mult/multu.
- DIV_CYCLES, default 10: busy cycles for div/divu.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset; one clock, reset asynchronous and active-low.
- E_valid  in  1  E stage holds a real (non-bubble) instruction.
- E_md_op  in  4  operation code from the E controller (md_pkg encoding).
- E_data1  in  32  forwarded rs value.
- E_data2  in  32  forwarded rt value.
- D_is_md  in  1  D-stage instruction is any md_pkg op other than MD_NONE.
- E_HL_data  out  32  HI (MD_MFHI) or LO (MD_MFLO), else 0; combinational from registers.
- E_MD_stall  out  1  stall request to AT_controller.
- busy  out  1  busy window active.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

## Operation

- States: IDLE, RUN.
- IDLE→RUN occurs on start:
  - start = E_valid & op∈{MULT,MULTU,DIV,DIVU} & state==IDLE.
  - On start, latch the result into hi_pend/lo_pend, computed from E_data1/E_data2 in the start cycle.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
- RUN behaviour:
  - busy=1 and cnt decrements each cycle.
  - When cnt==1: commit hi_pend/lo_pend to hi/lo, go to IDLE, cnt→0.
- Multiply results:
  - mult: signed 32×32→64; hi=[63:32], lo=[31:0].
  - multu: the unsigned equivalent.
- Divide results:
  - div: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - divu: the unsigned equivalent.
  - Divide by zero (div/divu, E_data2==0): a full DIV_CYCLES busy window runs, and hi/lo are left unchanged at commit.
  - div of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi/mtlo: when E_valid and state==IDLE, write E_data1 to hi/lo at the next edge; no busy window.
- mfhi/mflo: E_HL_data reads the current hi/lo; no state change.
- E_MD_stall = D_is_md & (busy | start).
- Illegal overlap (an md op with E_valid while in RUN) cannot occur given the stall. If it does occur, the op is ignored and an assertion fires in simulation.
- Reset (rst low, any time, including mid-RUN):
  - State→IDLE; cnt, hi, lo, hi_pend, lo_pend→0.
  - Outputs: busy=0, E_MD_stall=0, E_HL_data=0.
  - The pending result is discarded.

## Timing

- Start in cycle t:
  - busy=1 during t+1 … t+N (N = MULT_CYCLES or DIV_CYCLES).
  - hi/lo update at the edge ending t+N and are visible from t+N+1.
- An MD op in D during cycles t … t+N is stalled. It enters E at t+N+1 and therefore reads committed values.
- mthi/mtlo issued in cycle t: visible from t+1. An mfhi in E at t+1 reads the new value.
- Back-to-back starts are possible: a new start is legal at t+N+1.
- Non-MD instructions never stall on this block.

## Structure

- Package md_pkg holds:
  - The md_op enum: MD_NONE=0, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MFHI, MD_MFLO.
  - The state enum.
  - Default cycle-count constants.
- The E controller imports md_pkg for its decode.
- One sub-module, md_compute: purely combinational signed/unsigned mul/div with the division-special-case handling. The scheduler keeps all state, the counter and the stall logic.

## Test plan

- multu 0xFFFFFFFF×2 started at t → busy high t+1…t+5, D-stage mfhi stalled through t+5; hi=0x00000001, lo=0xFFFFFFFE at t+6.
- mult −3×7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB after 5 busy cycles; a non-MD add in D is not stalled.
- div −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles; divu 7/0 → hi/lo unchanged after 10 busy cycles.
- mtlo 0x12345678 at t, mflo in E at t+1 → E_HL_data=0x12345678; no stall asserted.
- rst low at busy cycle 3 of a div → busy=0, hi=lo=0 immediately; after release, an mflo returns 0 and the next mult runs normally.
- Back-to-back mult then div: the second is stalled in D until the first commits, and its start occurs exactly at t+6.
